// File: rtl/event_unpacker_if.sv
// Bundles the global-FIFO read port and the unpacked output stream of event_unpacker.
// "master" is the unpacker's view; "slave" is the FIFO/downstream environment's view.
interface event_unpacker_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] m_data;
  logic [2:0]       m_chan;
  logic [11:0]      m_bc;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (
    input  fifo_dout, fifo_empty, m_ready,
    output fifo_rd_en, m_data, m_chan, m_bc, m_valid, m_last
  );

  modport slave (
    output fifo_dout, fifo_empty, m_ready,
    input  fifo_rd_en, m_data, m_chan, m_bc, m_valid, m_last
  );
endinterface

// File: rtl/event_unpacker.sv
// Splits the global event FIFO stream (header + HOWMANY data words) into tagged
// output beats through a 2-entry skid buffer, reading only when space is guaranteed.
//
//   state | meaning
//   ------+-----------------------------------------------
//   S_HDR | next returned FIFO word is expected to be a header
//   S_DAT | next returned FIFO word is a data word of the current event
module event_unpacker #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  event_unpacker_if.master  io_bus,
  input  logic [SIZE-1:0]   i_howmany,
  output logic [15:0]       o_evt_count,
  output logic              o_err_frame,
  output logic              o_busy
);

  typedef enum logic {S_HDR, S_DAT} state_t;

  localparam logic [SIZE-1:0] CNT_ONE = SIZE'(1);

  state_t           r_state, w_state_nxt;
  logic [SIZE-1:0]  r_count, w_count_nxt;
  logic [2:0]       r_chan, w_chan_nxt;
  logic [11:0]      r_bc, w_bc_nxt;
  logic [15:0]      r_evt_count, w_evt_nxt;
  logic             r_err, w_err_nxt;
  logic             r_rd_pend;
  logic             r_rd_ok;

  logic [WIDTH-1:0] r_buf_data [2];
  logic [2:0]       r_buf_chan [2];
  logic [11:0]      r_buf_bc   [2];
  logic             r_buf_last [2];
  logic             r_wr_ptr, r_rd_ptr;
  logic [1:0]       r_occ;

  logic             w_push, w_push_last, w_pop, w_valid, w_rd_en;
  logic [1:0]       w_occ_after_pop, w_committed;

  assign w_valid         = (r_occ != 2'd0);
  assign w_pop           = w_valid & io_bus.m_ready;
  assign w_occ_after_pop = r_occ - {1'b0, w_pop};
  assign w_committed     = w_occ_after_pop + {1'b0, r_rd_pend};
  // r_rd_ok keeps the strobe low while reset is applied and for the first cycle after release
  assign w_rd_en         = r_rd_ok & ~io_bus.fifo_empty & (w_committed < 2'd2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_HDR;
      r_count     <= '0;
      r_chan      <= '0;
      r_bc        <= '0;
      r_evt_count <= '0;
      r_err       <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_rd_ok     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_chan      <= w_chan_nxt;
      r_bc        <= w_bc_nxt;
      r_evt_count <= w_evt_nxt;
      r_err       <= w_err_nxt;
      r_rd_pend   <= w_rd_en;
      r_rd_ok     <= 1'b1;
    end
  end

  // Each returned word is interpreted by the state current at its return cycle
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_chan_nxt  = r_chan;
    w_bc_nxt    = r_bc;
    w_evt_nxt   = r_evt_count;
    w_err_nxt   = r_err;
    w_push      = 1'b0;
    w_push_last = 1'b0;
    if (r_rd_pend) begin
      case (r_state)
        S_HDR: begin
          if (io_bus.fifo_dout[15]) begin
            w_err_nxt = 1'b1;
          end else begin
            w_chan_nxt  = io_bus.fifo_dout[14:12];
            w_bc_nxt    = io_bus.fifo_dout[11:0];
            w_count_nxt = i_howmany;
            w_evt_nxt   = r_evt_count + 16'd1;
            if (i_howmany != '0) w_state_nxt = S_DAT;
          end
        end
        S_DAT: begin
          w_push      = 1'b1;
          w_push_last = (r_count == CNT_ONE);
          w_count_nxt = r_count - CNT_ONE;
          if (r_count == CNT_ONE) w_state_nxt = S_HDR;
        end
        default: w_state_nxt = S_HDR;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
        r_buf_chan[i] <= '0;
        r_buf_bc[i]   <= '0;
        r_buf_last[i] <= 1'b0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= io_bus.fifo_dout;
        r_buf_chan[r_wr_ptr] <= r_chan;
        r_buf_bc[r_wr_ptr]   <= r_bc;
        r_buf_last[r_wr_ptr] <= w_push_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign io_bus.fifo_rd_en = w_rd_en;
  assign io_bus.m_valid    = w_valid;
  assign io_bus.m_data     = r_buf_data[r_rd_ptr];
  assign io_bus.m_chan     = r_buf_chan[r_rd_ptr];
  assign io_bus.m_bc       = r_buf_bc[r_rd_ptr];
  assign io_bus.m_last     = w_valid & r_buf_last[r_rd_ptr];

  assign o_evt_count = r_evt_count;
  assign o_err_frame = r_err;
  assign o_busy      = (r_state != S_HDR);

endmodule

// File: tb/tb_event_unpacker.sv
// Directed bench for event_unpacker: behavioural FIFO with 1-cycle read latency,
// beat monitor on the falling edge, hand-computed expectations per scenario.
module tb_event_unpacker;
  localparam int WIDTH = 16;
  localparam int SIZE  = 8;

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  c;
    logic [11:0] bc;
    logic        l;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [SIZE-1:0] howmany = '0;
  logic [15:0]     evt_count;
  logic            err_frame, busy;

  event_unpacker_if #(.WIDTH(WIDTH)) bus ();

  event_unpacker #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .io_bus      (bus),
    .i_howmany   (howmany),
    .o_evt_count (evt_count),
    .o_err_frame (err_frame),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] fq[$];
  int          gen_cnt = 0;
  logic        rd_flag = 1'b0;
  int          rd_count = 0;
  logic        busy_seen = 1'b0;
  beat_t       beats[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: a read strobed in one cycle presents its word just after the next edge
  always @(posedge clk) begin
    #1;
    if (rd_flag) begin
      if (fq.size() > 0)  bus.fifo_dout = fq.pop_front();
      else if (gen_cnt > 0) begin
        bus.fifo_dout = 16'h0000;
        gen_cnt--;
      end else bus.fifo_dout = 16'hDEAD;
    end
    bus.fifo_empty = (fq.size() == 0) && (gen_cnt == 0);
  end

  always @(negedge clk) begin
    rd_flag = bus.fifo_rd_en;
    if (bus.fifo_rd_en) rd_count++;
    if (bus.m_valid && bus.m_ready)
      beats.push_back({bus.m_data, bus.m_chan, bus.m_bc, bus.m_last});
    if (busy) busy_seen = 1'b1;
  end

  task automatic drv();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input logic [15:0] w);
    fq.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    drv();
    rst_n = 1'b0;
    drv();
    drv();
    fq.delete();
    gen_cnt = 0;
    bus.fifo_empty = 1'b1;
    beats.delete();
    busy_seen = 1'b0;
    rd_count = 0;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    int streak = 0;
    while (streak < 3 && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (fq.size() == 0 && gen_cnt == 0 && !busy && !bus.m_valid && !bus.fifo_rd_en)
        streak++;
      else
        streak = 0;
    end
    check({tag, "_idle"}, 32'(streak >= 3), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_en"}, 32'(bus.fifo_rd_en), 32'd0);
    check({tag, "_valid"}, 32'(bus.m_valid), 32'd0);
    check({tag, "_last"},  32'(bus.m_last), 32'd0);
    check({tag, "_data"},  32'(bus.m_data), 32'd0);
    check({tag, "_chan"},  32'(bus.m_chan), 32'd0);
    check({tag, "_bc"},    32'(bus.m_bc), 32'd0);
    check({tag, "_evt"},   32'(evt_count), 32'd0);
    check({tag, "_err"},   32'(err_frame), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  task automatic check_beat(input string tag, input int idx, input beat_t exp);
    beat_t b;
    b = (idx < beats.size()) ? beats[idx] : '0;
    check({tag, "_data"}, 32'(b.d),  32'(exp.d));
    check({tag, "_chan"}, 32'(b.c),  32'(exp.c));
    check({tag, "_bc"},   32'(b.bc), 32'(exp.bc));
    check({tag, "_last"}, 32'(b.l),  32'(exp.l));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] exp34 [3];
    int n;
    bus.fifo_dout  = '0;
    bus.fifo_empty = 1'b1;
    bus.m_ready    = 1'b1;

    // Reset values with data waiting in the FIFO
    put(16'h1111);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    do_reset();

    // Basic event, HOWMANY=3
    howmany = 8'd3;
    put(16'h3123); put(16'h0011); put(16'h0022); put(16'h0033);
    wait_idle("ev3", 60);
    check("ev3_nbeats", 32'(beats.size()), 32'd3);
    exp34[0] = 16'h0011; exp34[1] = 16'h0022; exp34[2] = 16'h0033;
    for (int i = 0; i < 3; i++)
      check_beat($sformatf("ev3_b%0d", i), i, '{exp34[i], 3'd3, 12'h123, (i == 2)});
    check("ev3_evt", 32'(evt_count), 32'd1);
    check("ev3_err", 32'(err_frame), 32'd0);

    // Zero-length events
    do_reset();
    howmany = 8'd0;
    put(16'h5001); put(16'h2002);
    wait_idle("ev0", 40);
    check("ev0_nbeats", 32'(beats.size()), 32'd0);
    check("ev0_evt", 32'(evt_count), 32'd2);
    check("ev0_busy_seen", 32'(busy_seen), 32'd0);
    check("ev0_err", 32'(err_frame), 32'd0);

    // Framing error resync, then sticky flag across a good header
    do_reset();
    howmany = 8'd1;
    put(16'h8ABC); put(16'h1005); put(16'hBEEF);
    wait_idle("ferr", 40);
    check("ferr_nbeats", 32'(beats.size()), 32'd1);
    check_beat("ferr_b0", 0, '{16'hBEEF, 3'd1, 12'h005, 1'b1});
    check("ferr_err", 32'(err_frame), 32'd1);
    check("ferr_evt", 32'(evt_count), 32'd1);
    drv();
    howmany = 8'd0;
    put(16'h1006);
    wait_idle("ferr2", 40);
    check("ferr_sticky", 32'(err_frame), 32'd1);
    check("ferr2_evt", 32'(evt_count), 32'd2);

    // Backpressure: buffer holds two words, HOWMANY change mid-event ignored
    do_reset();
    howmany = 8'd8;
    bus.m_ready = 1'b0;
    put(16'h2100);
    for (int i = 0; i < 8; i++) put(16'hA000 + 16'(i));
    repeat (10) @(negedge clk);
    check("bp_reads", 32'(rd_count), 32'd3);
    check("bp_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    check("bp_valid", 32'(bus.m_valid), 32'd1);
    check("bp_hold_data", 32'(bus.m_data), 32'hA000);
    check("bp_fifo_left", 32'(fq.size()), 32'd6);
    check("bp_nbeats", 32'(beats.size()), 32'd0);
    drv();
    howmany = 8'd2;
    bus.m_ready = 1'b1;
    wait_idle("bp", 80);
    check("bp_nbeats_end", 32'(beats.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check_beat($sformatf("bp_b%0d", i), i, '{16'hA000 + 16'(i), 3'd2, 12'h100, (i == 7)});

    // Reset mid-event, then a fresh header is accepted
    do_reset();
    howmany = 8'd4;
    put(16'h4010); put(16'hC001); put(16'hC002); put(16'hC003); put(16'hC004);
    n = 0;
    while (beats.size() < 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("mid_two_beats", 32'(beats.size() >= 2), 32'd1);
    drv();
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_rst");
    drv();
    fq.delete();
    bus.fifo_empty = 1'b1;
    beats.delete();
    howmany = 8'd1;
    rst_n = 1'b1;
    put(16'h7FFF); put(16'h0055);
    wait_idle("mid", 40);
    check("mid_nbeats", 32'(beats.size()), 32'd1);
    check_beat("mid_b0", 0, '{16'h0055, 3'd7, 12'hFFF, 1'b1});
    check("mid_evt", 32'(evt_count), 32'd1);

    // Event counter wrap: reach 0xFFFF, then 256 more headers
    do_reset();
    howmany = 8'd0;
    gen_cnt = 65535;
    bus.fifo_empty = 1'b0;
    wait_idle("wrap1", 70000);
    check("wrap_ffff", 32'(evt_count), 32'hFFFF);
    check("wrap_busy_seen", 32'(busy_seen), 32'd0);
    drv();
    gen_cnt = 256;
    bus.fifo_empty = 1'b0;
    wait_idle("wrap2", 400);
    check("wrap_00ff", 32'(evt_count), 32'h00FF);
    check("wrap_nbeats", 32'(beats.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
